// File: rtl/spi_sample_responder.sv
// SPI slave that streams AXI-Stream samples out MSB first, one sample per chipselect frame.
// Define SPI_RESPONDER_REPEAT_LAST_EN to resend the last loaded sample on underrun (default: zeros).
module spi_sample_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int LEAD_ZEROS  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    input  logic                  spi_clock,
    input  logic                  spi_chipselect,
    output logic                  spi_data,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [15:0]           underrun_count
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync;
    logic                    sclk_q, cs_q;
    logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                    seen_rise;
    logic [FRAME_BITS-1:0]   shreg, frame_word;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_count, count_next;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   load_sample, underrun_word;

    // Synchronizers reset low so a frame already in progress at reset release
    // is never seen as starting: a chipselect rise must come before a fall.
    // NOTE: every register written in always_ff uses <=, so all flops sample the same pre-edge values.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_chipselect};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_q;
    assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_q;
    assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_q;

    assign push       = s00_axis_tvalid & s00_axis_tready;
    assign pop        = (state == LOAD) && (fifo_count != 2'd0);
    assign count_next = fifo_count + {1'b0, push} - {1'b0, pop};

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge s00_axis_aclk) begin
        if (push) fifo_mem[wr_ptr] <= s00_axis_tdata;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            fifo_count      <= 2'd0;
            s00_axis_tready <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_count      <= count_next;
            s00_axis_tready <= (count_next != 2'd2);
        end
    end

`ifdef SPI_RESPONDER_REPEAT_LAST_EN
    logic [DATA_WIDTH-1:0] last_sample;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) last_sample <= '0;
        else if (pop)          last_sample <= fifo_mem[rd_ptr];
    end

    assign underrun_word = last_sample;
`else
    assign underrun_word = '0;
`endif

    // NOTE: defaults first so every path assigns and no latch is inferred.
    always_comb begin
        load_sample = underrun_word;
        if (fifo_count != 2'd0) load_sample = fifo_mem[rd_ptr];
        frame_word = FRAME_BITS'(load_sample);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            seen_rise      <= 1'b0;
            spi_data       <= 1'b0;
            frame_done     <= 1'b0;
            frame_abort    <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (state != IDLE && sclk_rise) seen_rise <= 1'b1;

            case (state)
                IDLE: begin
                    spi_data <= 1'b0;
                    if (cs_fall) begin
                        state     <= LOAD;
                        seen_rise <= 1'b0;
                    end
                end
                LOAD: begin
                    if (fifo_count == 2'd0 && underrun_count != 16'hFFFF)
                        underrun_count <= underrun_count + 16'd1;
                    if (cs_rise) begin
                        state       <= IDLE;
                        spi_data    <= 1'b0;
                        frame_abort <= 1'b1;
                    end else begin
                        spi_data <= frame_word[FRAME_BITS-1];
                        shreg    <= frame_word << 1;
                        bit_cnt  <= CNT_W'(1);
                        state    <= (FRAME_BITS == 1) ? HOLD : SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        spi_data    <= 1'b0;
                        frame_abort <= 1'b1;
                    end else if (sclk_fall && seen_rise) begin
                        spi_data <= shreg[FRAME_BITS-1];
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        state      <= IDLE;
                        spi_data   <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (sclk_fall && seen_rise) begin
                        spi_data <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sample_responder.sv
// Directed bench for spi_sample_responder: a bit-banged SPI master captures frames and a
// scoreboard queue holds the expected capture for each frame in push order.
module tb_spi_sample_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tdata;
    logic        tvalid, tready;
    logic        sclk, cs;
    logic        sdata, fdone, fabort;
    logic [15:0] ucnt;
    logic [7:0]  lz_tdata;
    logic        lz_tvalid, lz_tready, lz_sdata, lz_done, lz_abort;
    logic [15:0] lz_ucnt;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    bit          mon_en = 1'b0;
    bit          tready_dropped = 1'b0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    spi_sample_responder u_dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (tdata),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tready  (tready),
        .spi_clock        (sclk),
        .spi_chipselect   (cs),
        .spi_data         (sdata),
        .frame_done       (fdone),
        .frame_abort      (fabort),
        .underrun_count   (ucnt)
    );

    spi_sample_responder #(.DATA_WIDTH(8), .LEAD_ZEROS(3)) u_dut_lz (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (lz_tdata),
        .s00_axis_tvalid  (lz_tvalid),
        .s00_axis_tready  (lz_tready),
        .spi_clock        (sclk),
        .spi_chipselect   (cs),
        .spi_data         (lz_sdata),
        .frame_done       (lz_done),
        .frame_abort      (lz_abort),
        .underrun_count   (lz_ucnt)
    );

    always @(negedge clk) begin
        if (fdone === 1'b1)  done_cnt++;
        if (fabort === 1'b1) abort_cnt++;
        if (mon_en && tready !== 1'b1) tready_dropped = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one sample and hold it until the DUT accepts it (bounded).
    task automatic axis_push(input bit sel, input logic [15:0] d, input logic [63:0] exp);
        int guard = 0;
        exp_q.push_back(exp);
        if (sel) begin
            lz_tdata  = d[7:0];
            lz_tvalid = 1'b1;
            while (lz_tready !== 1'b1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            lz_tvalid = 1'b0;
        end else begin
            tdata  = d;
            tvalid = 1'b1;
            while (tready !== 1'b1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
            tvalid = 1'b0;
        end
        check("push_accepted", 64'(guard < 1000), 64'd1);
    endtask

    // SPI master at 1/10 of clk; samples spi_data on each rising spi_clock edge.
    task automatic spi_xfer(input int nclk, input bit cpol, input bit sel, output logic [63:0] cap);
        cap  = '0;
        sclk = cpol;
        wait_clks(4);
        cs = 1'b0;
        wait_clks(8);
        for (int i = 0; i < nclk; i++) begin
            if (cpol) begin
                sclk = 1'b0;
                wait_clks(5);
                cap  = {cap[62:0], (sel ? lz_sdata : sdata)};
                sclk = 1'b1;
                wait_clks(5);
            end else begin
                cap  = {cap[62:0], (sel ? lz_sdata : sdata)};
                sclk = 1'b1;
                wait_clks(5);
                sclk = 1'b0;
                wait_clks(5);
            end
        end
        wait_clks(3);
        cs = 1'b1;
        wait_clks(10);
        sclk = 1'b0;
        wait_clks(4);
    endtask

    task automatic run_frame(input string tag, input int nclk, input bit cpol, input bit sel);
        logic [63:0] cap, exp;
        spi_xfer(nclk, cpol, sel, cap);
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else                   exp = 64'hDEAD_BEEF_DEAD_BEEF;
        check(tag, cap, exp);
    endtask

    initial begin
        int  d0, a0;
        bit  nonzero;

        rst_n     = 1'b0;
        tdata     = '0;
        tvalid    = 1'b0;
        lz_tdata  = '0;
        lz_tvalid = 1'b0;
        sclk      = 1'b0;
        cs        = 1'b1;
        wait_clks(3);
        check("reset_tready", 64'(tready), 64'd0);
        check("reset_spi_data", 64'(sdata), 64'd0);
        check("reset_frame_done", 64'(fdone), 64'd0);
        check("reset_underrun", 64'(ucnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_reset", 64'(tready), 64'd1);
        wait_clks(5);

        // Single frame, CPOL 0.
        axis_push(1'b0, 16'hA5C3, 64'hA5C3);
        mon_en = 1'b1;
        run_frame("frame_a5c3", 16, 1'b0, 1'b0);
        mon_en = 1'b0;
        check("done_count_1", 64'(done_cnt), 64'd1);
        check("abort_count_0", 64'(abort_cnt), 64'd0);
        check("tready_held_high", 64'(tready_dropped), 64'd0);

        // Back-to-back pushes fill the FIFO; third waits for the first LOAD.
        axis_push(1'b0, 16'h1234, 64'h1234);
        axis_push(1'b0, 16'h5678, 64'h5678);
        check("tready_low_when_full", 64'(tready), 64'd0);
        fork
            axis_push(1'b0, 16'h9ABC, 64'h9ABC);
            run_frame("frame_1234", 16, 1'b0, 1'b0);
        join
        run_frame("frame_5678", 16, 1'b0, 1'b0);
        run_frame("frame_9abc_cpol1", 16, 1'b1, 1'b0);
        check("done_count_4", 64'(done_cnt), 64'd4);

        // Underrun after a frame of 0x00FF.
        axis_push(1'b0, 16'h00FF, 64'h00FF);
        run_frame("frame_00ff", 16, 1'b0, 1'b0);
`ifdef SPI_RESPONDER_REPEAT_LAST_EN
        exp_q.push_back(64'h00FF);
`else
        exp_q.push_back(64'h0000);
`endif
        run_frame("frame_underrun", 16, 1'b0, 1'b0);
        check("underrun_count_1", 64'(ucnt), 64'd1);
        check("done_count_6", 64'(done_cnt), 64'd6);

        // Early chipselect release after 5 bits, then a full frame.
        axis_push(1'b0, 16'hFFFF, 64'h1F);
        axis_push(1'b0, 16'h8001, 64'h8001);
        run_frame("frame_abort_bits", 5, 1'b0, 1'b0);
        check("abort_count_1", 64'(abort_cnt), 64'd1);
        check("done_after_abort", 64'(done_cnt), 64'd6);
        run_frame("frame_8001", 16, 1'b0, 1'b0);
        check("done_count_7", 64'(done_cnt), 64'd7);

        // Reset mid-frame, release with chipselect still low.
        cs = 1'b0;
        wait_clks(8);
        repeat (3) begin
            sclk = 1'b1;
            wait_clks(5);
            sclk = 1'b0;
            wait_clks(5);
        end
        rst_n = 1'b0;
        wait_clks(3);
        check("midreset_spi_data", 64'(sdata), 64'd0);
        check("midreset_tready", 64'(tready), 64'd0);
        d0 = done_cnt;
        a0 = abort_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_midreset", 64'(tready), 64'd1);
        check("underrun_cleared", 64'(ucnt), 64'd0);
        nonzero = 1'b0;
        repeat (4) begin
            sclk = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (sdata !== 1'b0) nonzero = 1'b1;
            end
            sclk = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (sdata !== 1'b0) nonzero = 1'b1;
            end
        end
        check("partial_frame_data_zero", 64'(nonzero), 64'd0);
        cs = 1'b1;
        wait_clks(10);
        check("partial_frame_no_done", 64'(done_cnt - d0), 64'd0);
        check("partial_frame_no_abort", 64'(abort_cnt - a0), 64'd0);
        check("partial_frame_no_underrun", 64'(ucnt), 64'd0);
        axis_push(1'b0, 16'h3C5A, 64'h3C5A);
        run_frame("frame_after_reset", 16, 1'b0, 1'b0);
        check("underrun_after_reset", 64'(ucnt), 64'd0);

        // Leading zeros: 3 zeros + 8-bit 0xFF, 16 clocks.
        axis_push(1'b1, 16'h00FF, 64'h1FE0);
        run_frame("frame_lead_zeros", 16, 1'b0, 1'b1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sample_responder.md
SPI_SAMPLE_RESPONDER -- requirements
Module: spi_sample_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each stream sample and of the data field in an SPI frame.
REQ-002 Parameter LEAD_ZEROS, default 0: number of zero bits sent before the data field; LEAD_ZEROS+DATA_WIDTH SHALL be at most 64.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for the SPI inputs, allowed range 2..3.
REQ-004 Port s00_axis_aclk, input, 1 bit: single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port s00_axis_aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port s00_axis_tdata, input, DATA_WIDTH bits: sample to transmit.
REQ-007 Port s00_axis_tvalid, input, 1 bit: sample valid.
REQ-008 Port s00_axis_tready, output, 1 bit: block can accept a sample.
REQ-009 Port spi_clock, input, 1 bit: SPI serial clock from the master, asynchronous to s00_axis_aclk.
REQ-010 Port spi_chipselect, input, 1 bit: active-low frame select from the master, asynchronous.
REQ-011 Port spi_data, output, 1 bit: serial data to the master, MSB first.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse when a complete frame ends.
REQ-013 Port frame_abort, output, 1 bit: one-cycle pulse when a frame ends early.
REQ-014 Port underrun_count, output, 16 bits: saturating count of frames started with no buffered sample.

Function
REQ-015 spi_clock and spi_chipselect SHALL each pass through SYNC_STAGES flops before edge detection; s00_axis_aclk SHALL be at least 8x the spi_clock frequency.
REQ-016 Buffering SHALL be a 2-entry FIFO; s00_axis_tready = not full; a transfer occurs when tvalid and tready are both high in the same cycle.
REQ-017 A push and a pop in the same cycle SHALL both take effect; push into a full FIFO SHALL never occur, because tready is low.
REQ-018 State machine: IDLE -> LOAD on synchronized chipselect falling edge; LOAD -> SHIFT after 1 cycle; SHIFT -> HOLD after the last frame bit is driven; SHIFT or HOLD -> IDLE on chipselect rising edge.
REQ-019 In LOAD, the FIFO head SHALL be popped into a shift register of LEAD_ZEROS zeros followed by the sample MSB first.
REQ-020 Frame bit 0 SHALL appear on spi_data no later than 3 cycles after the synchronized chipselect falling edge.
REQ-021 Each subsequent bit SHALL be driven within 3 cycles of a synchronized spi_clock falling edge, counting only falling edges preceded by a rising edge in the same frame; this makes CPOL 0 and CPOL 1 equivalent.
REQ-022 After LEAD_ZEROS+DATA_WIDTH bits, spi_data SHALL be 0 for further spi_clock edges while chipselect stays low (HOLD).
REQ-023 While chipselect is high, spi_data SHALL be 0; the output is never tristated.
REQ-024 Chipselect rising edge in HOLD SHALL pulse frame_done; rising edge in LOAD or SHIFT SHALL pulse frame_abort, the popped sample is discarded, and the FIFO is unaffected.
REQ-025 FIFO empty at LOAD SHALL increment underrun_count, saturating at 65535, and send the underrun word defined in REQ-030/031.
REQ-026 Spurious spi_clock edges while chipselect is high SHALL be ignored.

Reset
REQ-027 During reset: FIFO empty, s00_axis_tready=0, spi_data=0, frame_done=0, frame_abort=0, underrun_count=0, state IDLE, last-sample register 0.
REQ-028 s00_axis_tready SHALL rise on the first clock after reset release.
REQ-029 If chipselect is low at reset release, the block SHALL stay in IDLE, driving 0, until a chipselect rising edge, then a falling edge, is seen; no pulse or count SHALL be generated for that partial frame.

Configuration
REQ-030 With macro SPI_RESPONDER_REPEAT_LAST_EN defined, an underrun frame SHALL transmit the last sample successfully loaded, or 0 if none since reset.
REQ-031 Without SPI_RESPONDER_REPEAT_LAST_EN, an underrun frame SHALL transmit all zeros and the last-sample register SHALL be omitted.

Verification
REQ-032 Push 0xA5C3, run a 16-clock frame at 1/10 clock rate -> master captures 0xA5C3, frame_done pulses once, tready high throughout.
REQ-033 Push 0x1234, 0x5678, 0x9ABC back-to-back -> tready low after 2 transfers, third accepted at frame 1 LOAD; frames read 0x1234, 0x5678, 0x9ABC.
REQ-034 Frame with empty FIFO after a frame sending 0x00FF -> underrun_count=1; captures 0x00FF with the macro, 0x0000 without.
REQ-035 Raise chipselect after 5 bits of 0xFFFF, then run a full frame with 0x8001 queued -> frame_abort pulse; next frame reads 0x8001.
REQ-036 Assert reset mid-frame, release with chipselect still low -> spi_data 0 until a new frame; that frame reads the next pushed sample; counters 0.
REQ-037 LEAD_ZEROS=3, DATA_WIDTH=8, sample 0xFF, 16 clocks -> captured 0001_1111_1110_0000.
